// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared state and redirect-select encodings for the PC generator
package pc_gen_pkg;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SEL_HOLD = 2'd0,
      SEL_SEQ  = 2'd1,
      SEL_BR   = 2'd2,
      SEL_TRAP = 2'd3
   } sel_t;

   localparam int unsigned PC_STEP = 4;

   // Trap beats branch beats a sequential step; otherwise the PC holds.
   function automatic sel_t pick_sel(input logic trap, input logic br, input logic acc);
      return trap ? SEL_TRAP : br ? SEL_BR : acc ? SEL_SEQ : SEL_HOLD;
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC mux with redirect priority and word alignment
module pc_next_sel
   import pc_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vec,
   input  logic            br_valid,
   input  logic [XLEN-1:0] br_target,
   input  logic            accept,
   output logic [XLEN-1:0] next_pc,
   output logic            redirect
);

   sel_t sel;

   // Pick the source and force redirect targets onto a word boundary.
   always_comb begin
      sel      = pick_sel(trap_valid, br_valid, accept);
      redirect = trap_valid || br_valid;
      next_pc  = sel == SEL_TRAP ? {trap_vec[XLEN-1:2], 2'b00} :
                 sel == SEL_BR   ? {br_target[XLEN-1:2], 2'b00} :
                 sel == SEL_SEQ  ? pc + XLEN'(PC_STEP) : pc;
   end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with boot/run/halt control and accepted-fetch counter
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter int              CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             stall,
   input  logic             halt_req,
   input  logic             trap_valid,
   input  logic [XLEN-1:0]  trap_vec,
   input  logic             br_valid,
   input  logic [XLEN-1:0]  br_target,
   input  logic             fetch_ready,
   output logic             fetch_valid,
   output logic [XLEN-1:0]  pc,
   output logic             fetch_kill,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_cnt
);

   state_t          state;
   state_t          state_nx;
   logic            accept;
   logic            redirect;
   logic [XLEN-1:0] pc_nx;

   assign fetch_valid = (state == RUN) && !stall;
   assign accept      = fetch_valid && fetch_ready;
   assign halted      = state == HALTED;

   pc_next_sel #(.XLEN(XLEN)) u_sel (
      .pc         (pc),
      .trap_valid (trap_valid),
      .trap_vec   (trap_vec),
      .br_valid   (br_valid),
      .br_target  (br_target),
      .accept     (accept),
      .next_pc    (pc_nx),
      .redirect   (redirect)
   );

   // Next state: a redirect keeps or returns us to RUN; halt waits for any offered fetch to be taken.
   always_comb begin
      state_nx = state;
      case (state)
         BOOT:    state_nx = RUN;
         RUN:     state_nx = (!redirect && halt_req && !(fetch_valid && !fetch_ready)) ? HALTED : RUN;
         HALTED:  state_nx = redirect ? RUN : HALTED;
         default: state_nx = BOOT;
      endcase
   end

   // State, PC, counter and kill pulse; reset abandons any in-flight fetch silently.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= BOOT;
         pc         <= RESET_VEC;
         fetch_cnt  <= '0;
         fetch_kill <= 1'b0;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         fetch_cnt  <= accept ? fetch_cnt + 1'b1 : fetch_cnt;
         fetch_kill <= redirect;
      end
   end

endmodule
